fnd_scan_controller: RTL

Time-multiplexed driver for the stopwatch's 4-digit common-anode 7-segment display (FND). It consumes the single-cycle scan tick from the FND clock divider and four BCD digits plus decimal points from the stopwatch datapath. On each tick it advances to the next digit, inserting a short all-off interval to suppress ghosting. It drives registered, active-low common and segment pins directly to the board.

---
 rtl/fnd_scan_controller_pkg.sv | 29 ++
 rtl/fnd_scan_controller_if.sv | 27 ++
 rtl/bcd_to_7seg.sv | 34 +++
 rtl/fnd_scan_controller.sv | 97 +++++++++
 4 files changed

// File: rtl/fnd_scan_controller_pkg.sv
// ============================================================================
// fnd_scan_controller_pkg
// Shared 7-segment constants for the FND display blocks.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fnd_scan_controller_pkg;

   // Active-low segment patterns, bit order [6:0] = g..a
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [3:0] COM_ALL_OFF  = 4'b1111;
   localparam logic [7:0] FONT_ALL_OFF = 8'hFF;
   localparam int         DP_BIT       = 7;

endpackage

`default_nettype wire

// File: rtl/fnd_scan_controller_if.sv
// ============================================================================
// fnd_scan_controller_if
// Tick/BCD inputs and FND pin outputs of the scan controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface fnd_scan_controller_if;
   logic        i_tick;
   logic [15:0] i_bcd;
   logic [3:0]  i_dp;
   logic [3:0]  o_fnd_com;
   logic [7:0]  o_fnd_font;
   logic        o_frame;

   modport master (
      output i_tick, i_bcd, i_dp,
      input  o_fnd_com, o_fnd_font, o_frame
   );

   modport slave (
      input  i_tick, i_bcd, i_dp,
      output o_fnd_com, o_fnd_font, o_frame
   );
endinterface

`default_nettype wire

// File: rtl/bcd_to_7seg.sv
// ============================================================================
// bcd_to_7seg
// Combinational BCD to active-low 7-segment decoder; 10..15 decode to blank.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bcd_to_7seg
   import fnd_scan_controller_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      case (bcd_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/fnd_scan_controller.sv
// ============================================================================
// fnd_scan_controller
// 4-digit multiplexed FND driver with anti-ghost blanking and frame snapshot.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fnd_scan_controller
   import fnd_scan_controller_pkg::*;
#(
   parameter int BLANK_CYCLES = 1000,
   parameter bit LZ_BLANK     = 1'b0
) (
   input  logic                  clk,
   input  logic                  reset,
   fnd_scan_controller_if.slave  bus
);

   localparam int              CNT_W      = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES);

   logic [1:0]       digit_q, digit_d;
   logic [CNT_W-1:0] blank_q, blank_d;
   logic [15:0]      shadow_bcd_q, shadow_bcd_d;
   logic [3:0]       shadow_dp_q, shadow_dp_d;
   logic [3:0]       com_q, com_d;
   logic [7:0]       font_q, font_d;
   logic             frame_q, frame_d;

   logic [3:0]       nibble;
   logic [6:0]       seg;
   logic             lz_hide;

   always_comb begin
      digit_d      = digit_q;
      blank_d      = blank_q;
      shadow_bcd_d = shadow_bcd_q;
      shadow_dp_d  = shadow_dp_q;
      frame_d      = 1'b0;
      if (bus.i_tick) begin
         digit_d = digit_q + 2'd1;
         blank_d = BLANK_LOAD;
         // Latch a whole frame at the wrap so all four digits share one sample
         if (digit_q == 2'd3) begin
            shadow_bcd_d = bus.i_bcd;
            shadow_dp_d  = bus.i_dp;
            frame_d      = 1'b1;
         end
      end else if (blank_q != '0) begin
         blank_d = blank_q - CNT_W'(1);
      end
   end

   assign nibble  = shadow_bcd_q[{digit_q, 2'b00} +: 4];
   // A digit is a leading zero when it and every digit to its left are zero
   assign lz_hide = LZ_BLANK && (digit_q != 2'd0) &&
                    ((shadow_bcd_q >> {digit_q, 2'b00}) == 16'h0000);

   bcd_to_7seg u_dec (
      .bcd_i (nibble),
      .seg_o (seg)
   );

   always_comb begin
      com_d  = (blank_q != '0) ? COM_ALL_OFF : ~(4'b0001 << digit_q);
      font_d = FONT_ALL_OFF;
      font_d[6:0]    = lz_hide ? SEG_BLANK : seg;
      font_d[DP_BIT] = ~shadow_dp_q[digit_q];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         digit_q      <= 2'd0;
         blank_q      <= '0;
         shadow_bcd_q <= 16'h0000;
         shadow_dp_q  <= 4'h0;
         com_q        <= COM_ALL_OFF;
         font_q       <= FONT_ALL_OFF;
         frame_q      <= 1'b0;
      end else begin
         digit_q      <= digit_d;
         blank_q      <= blank_d;
         shadow_bcd_q <= shadow_bcd_d;
         shadow_dp_q  <= shadow_dp_d;
         com_q        <= com_d;
         font_q       <= font_d;
         frame_q      <= frame_d;
      end
   end

   assign bus.o_fnd_com  = com_q;
   assign bus.o_fnd_font = font_q;
   assign bus.o_frame    = frame_q;

endmodule

`default_nettype wire
